// File: rtl/neuron_scheduler.sv
// neuron_scheduler
//   Time-multiplexes NUM_NEURONS logical neurons onto one shared evaluation
//   datapath. A spike volley is latched on the in_valid/in_ready handshake,
//   then one neuron per cycle sums the weights of its active synapses and
//   compares the sum with THRESHOLD. The result vector is held in DONE until
//   the downstream consumes it.
//
//   Macros normally supplied by internal_defines.vh: NUM_SPIKES, WBITS,
//   THRESHOLD (defaults below are used only when the include is absent).
//   Optional feature macro: NEURON_SCHED_WTA_EN -- winner-take-all output,
//   only the firing neuron with the largest sum (lowest index on a tie).
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       volley handshake; in_spikes is the volley
//   wr_en, wr_neuron,       weight write port, honoured only in IDLE without
//   wr_syn, wr_data         a simultaneous handshake
//   out_valid/out_ready     result handshake; out_spikes bit k = neuron k
//   busy                    high while evaluating or holding a result

`ifndef NUM_SPIKES
`define NUM_SPIKES 8
`endif
`ifndef WBITS
`define WBITS 3
`endif
`ifndef THRESHOLD
`define THRESHOLD 8
`endif

// One synapse lane: gate the weight by its spike bit and widen it to the
// accumulator width.
module neuron_syn_term #(
  parameter int WB   = 3,
  parameter int SUMW = 7
) (
  input  logic            spike,
  input  logic [WB-1:0]   weight,
  output logic [SUMW-1:0] term
);
  assign term = spike ? SUMW'(weight) : '0;
endmodule

module neuron_scheduler #(
  parameter int NUM_NEURONS = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [`NUM_SPIKES-1:0]           in_spikes,
  output logic                             in_ready,
  input  logic                             wr_en,
  input  logic [$clog2(NUM_NEURONS)-1:0]   wr_neuron,
  input  logic [$clog2(`NUM_SPIKES)-1:0]   wr_syn,
  input  logic [`WBITS-1:0]                wr_data,
  output logic                             out_valid,
  output logic [NUM_NEURONS-1:0]           out_spikes,
  input  logic                             out_ready,
  output logic                             busy
);
  localparam int NS   = `NUM_SPIKES;
  localparam int WB   = `WBITS;
  localparam int NW   = $clog2(NUM_NEURONS);
  localparam int SW   = $clog2(NS);
  // Wide enough that NS maximal weights cannot overflow.
  localparam int SUMW = WB + SW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                            state;
  logic [NW-1:0]                         cnt;
  logic [NS-1:0]                         spk;
  logic [NUM_NEURONS-1:0]                res;
  logic [NUM_NEURONS-1:0][NS-1:0][WB-1:0] weights;

  logic [NS-1:0][SUMW-1:0] term;
  logic [SUMW-1:0]         sum;
  logic                    fire;
  logic                    hs;
  logic                    wr_ok;
  logic                    last;

  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign out_spikes = out_valid ? res : '0;

  assign hs    = in_valid && in_ready;
  // A handshake in the same cycle takes priority and drops the write.
  assign wr_ok = in_ready && !hs && wr_en && (int'(wr_neuron) < NUM_NEURONS);
  assign last  = (cnt == NW'(NUM_NEURONS - 1));

  for (genvar i = 0; i < NS; i++) begin : g_syn
    neuron_syn_term #(.WB(WB), .SUMW(SUMW)) u_term (
      .spike  (spk[i]),
      .weight (weights[cnt][i]),
      .term   (term[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NS; i++) sum = sum + term[i];
  end

  assign fire = (sum >= SUMW'(`THRESHOLD));

`ifdef NEURON_SCHED_WTA_EN
  // Running winner: strict '>' while scanning upward keeps the lowest index
  // on a tie. The next-state values feed the result on the last neuron so
  // winner-take-all costs no extra cycle.
  logic            win_any;
  logic [SUMW-1:0] win_max;
  logic [NW-1:0]   win_idx;
  logic            upd;
  logic            nxt_any;
  logic [NW-1:0]   nxt_idx;

  always_comb begin
    upd     = fire && (!win_any || (sum > win_max));
    nxt_any = win_any || fire;
    nxt_idx = upd ? cnt : win_idx;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      spk     <= '0;
      res     <= '0;
      weights <= '0;
`ifdef NEURON_SCHED_WTA_EN
      win_any <= 1'b0;
      win_max <= '0;
      win_idx <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (hs) begin
            spk   <= in_spikes;
            cnt   <= '0;
            res   <= '0;
            state <= S_EVAL;
`ifdef NEURON_SCHED_WTA_EN
            win_any <= 1'b0;
            win_max <= '0;
            win_idx <= '0;
`endif
          end else if (wr_ok) begin
            weights[wr_neuron][wr_syn] <= wr_data;
          end
        end
        S_EVAL: begin
`ifdef NEURON_SCHED_WTA_EN
          win_any <= nxt_any;
          win_idx <= nxt_idx;
          if (upd) win_max <= sum;
          if (last) begin
            res          <= '0;
            res[nxt_idx] <= nxt_any;
          end
`else
          res[cnt] <= fire;
`endif
          cnt <= cnt + 1'b1;
          if (last) state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/neuron_scheduler.md
NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

Interface
REQ-001 Parameter: NUM_NEURONS, default 4, number of logical neurons time-multiplexed onto one shared evaluation datapath; legal range 2..16.
REQ-002 Macros from internal_defines.vh: `num_spikes` (synapses per neuron), `WBITS` (weight width), `THRESHOLD` (fire level).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named clock and reset as elsewhere in the codebase.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  a spike volley is presented.
REQ-007 in_spikes  input  `num_spikes`  spike volley, one bit per synapse.
REQ-008 in_ready  output  1  the scheduler accepts a volley this cycle.
REQ-009 wr_en  input  1  weight write strobe.
REQ-010 wr_neuron  input  $clog2(NUM_NEURONS)  target neuron index.
REQ-011 wr_syn  input  $clog2(`num_spikes)  target synapse index.
REQ-012 wr_data  input  `WBITS`  weight value to write.
REQ-013 out_valid  output  1  a result vector is available.
REQ-014 out_spikes  output  NUM_NEURONS  fire result, bit k belongs to neuron k.
REQ-015 out_ready  input  1  downstream consumes the result.
REQ-016 busy  output  1  high in the EVAL and DONE states.

Function
REQ-017 The block SHALL hold an internal weight file of NUM_NEURONS x `num_spikes` entries, each `WBITS` wide.
REQ-018 The FSM SHALL have exactly three states: IDLE, EVAL and DONE.
REQ-019 in_ready SHALL be 1 only in IDLE.
REQ-020 A handshake is in_valid&in_ready; on a handshake the block SHALL latch in_spikes, clear the neuron counter and enter EVAL.
REQ-021 In EVAL, at counter k, the block SHALL compute sum_k, the unsigned sum of weight[k][i] over every i with the latched spike i = 1, and register the fire bit.
REQ-022 The sum width SHALL be `WBITS`+$clog2(`num_spikes`)+1 so the sum never overflows.
REQ-023 Neuron k fires iff sum_k >= `THRESHOLD`.
REQ-024 The counter SHALL advance by one per cycle; after k = NUM_NEURONS-1 the FSM SHALL enter DONE, so a handshake at cycle t gives out_valid = 1 at cycle t+NUM_NEURONS+1.
REQ-025 In DONE, out_valid SHALL be 1 and out_spikes SHALL hold stable until out_ready = 1; that cycle SHALL return the FSM to IDLE.
REQ-026 A volley offered in the same cycle the FSM returns to IDLE SHALL NOT be accepted; in_ready rises in the next cycle.
REQ-027 A weight write SHALL take effect only in IDLE and only when no handshake occurs in the same cycle.
REQ-028 Weight writes in EVAL or DONE, and writes with wr_neuron >= NUM_NEURONS, SHALL be ignored.
REQ-029 A write and a handshake in the same IDLE cycle: the handshake SHALL win and the write SHALL be dropped.
REQ-030 out_spikes SHALL be 0 whenever out_valid = 0.

Reset
REQ-031 Reset SHALL take effect on the clock edge, including mid-EVAL or mid-DONE, and SHALL abort any in-flight volley.
REQ-032 After reset: state IDLE, in_ready = 1, out_valid = 0, out_spikes = 0, busy = 0, counter = 0, all weights = 0.

Configuration
REQ-033 With macro NEURON_SCHED_WTA_EN defined, the block SHALL apply winner-take-all.
REQ-034 Under winner-take-all, only the firing neuron with the largest sum sets its out_spikes bit; a tie goes to the lowest index.
REQ-035 If no neuron fires, out_spikes SHALL be 0 under winner-take-all.
REQ-036 Under winner-take-all, the running max sum and winner index SHALL be tracked during EVAL and SHALL add no latency.
REQ-037 Without NEURON_SCHED_WTA_EN, every neuron whose sum meets the threshold SHALL set its out_spikes bit.

Verification
All scenarios use `num_spikes` = 8, `WBITS` = 3, `THRESHOLD` = 8, NUM_NEURONS = 4.
REQ-038 Reset, then volley 8'hFF with out_ready = 1 -> out_valid at t+5, out_spikes = 4'b0000 (all weights 0).
REQ-039 Write weight[2][0..3] = 2, volley 8'h0F -> out_spikes = 4'b0100 (sum 8, boundary fires); same test with weight[2][3] = 1 -> 4'b0000 (sum 7).
REQ-040 Hold out_ready = 0 for 10 cycles in DONE -> out_valid and out_spikes stay stable and in_ready = 0; then release -> IDLE next cycle.
REQ-041 Assert wr_en during EVAL, and again together with a handshake -> stored weight is unchanged; a readback volley confirms it.
REQ-042 With NEURON_SCHED_WTA_EN: neuron 1 sum 9, neuron 3 sum 12 -> 4'b1000; neurons 0 and 2 both sum 10 -> 4'b0001.
REQ-043 Assert reset at EVAL k = 2 -> next cycle in IDLE with out_valid = 0; a subsequent volley gives all-zero outputs because weights were cleared.
